// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU op encodings and shared helpers
// Contents:
//   ALU_OP_W    width of the op field
//   alu_op_e    RV32I integer ops followed by the M-extension ops
//   is_muldiv   true for the M-extension encodings
package alu_pkg;

    localparam int ALU_OP_W = 5;

    typedef enum logic [ALU_OP_W-1:0] {
        ADD    = 5'd0,
        SUB    = 5'd1,
        SLT    = 5'd2,
        SLTU   = 5'd3,
        XOR    = 5'd4,
        OR     = 5'd5,
        AND    = 5'd6,
        SLL    = 5'd7,
        SRL    = 5'd8,
        SRA    = 5'd9,
        MUL    = 5'd10,
        MULH   = 5'd11,
        MULHSU = 5'd12,
        MULHU  = 5'd13,
        DIV    = 5'd14,
        DIVU   = 5'd15,
        REM    = 5'd16,
        REMU   = 5'd17
    } alu_op_e;

    function automatic logic is_muldiv(input alu_op_e op);
        return op inside {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU};
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - iterative shift-add multiplier / restoring divider
// Present only when ALU_MULDIV_EN is defined.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         capture op/a/b and begin XLEN iterations
//   op, a, b      M-extension op and operands (sampled on start)
//   done          high in the last iteration cycle; result valid then
//   result        sign-corrected XLEN-bit result (valid with done)
`ifdef ALU_MULDIV_EN
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  alu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    logic [CW-1:0]     count;
    logic              busy;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_next;
    logic [XLEN-1:0]   mag_b;
    logic              div_q;
    logic              hi_q;
    logic              rem_q;
    logic              neg_q;
    logic              neg_rem_q;

    // Operand conditioning at start
    logic              signed_a;
    logic              signed_b;
    logic              neg_a;
    logic              neg_b;
    logic [XLEN-1:0]   mag_a_in;
    logic [XLEN-1:0]   mag_b_in;

    always_comb begin
        signed_a = op inside {MULH, MULHSU, DIV, REM};
        signed_b = op inside {MULH, DIV, REM};
        neg_a    = signed_a & a[XLEN-1];
        neg_b    = signed_b & b[XLEN-1];
        // The most-negative value negates to itself, which is the correct
        // unsigned magnitude.
        mag_a_in = neg_a ? (~a + 1'b1) : a;
        mag_b_in = neg_b ? (~b + 1'b1) : b;
    end

    // One iteration step on the shared 2*XLEN register.
    // mul: {partial product high, multiplier low}, shift right with add.
    // div: {partial remainder high, dividend/quotient low}, shift left with
    //      trial subtract; the remainder stays below mag_b so it fits XLEN.
    logic [XLEN:0] sum;
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    always_comb begin
        sum      = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mag_b};
        rem_sh   = acc[2*XLEN-1:XLEN-1];
        diff     = rem_sh - {1'b0, mag_b};
        acc_next = acc;
        if (div_q) begin
            if (!diff[XLEN]) begin
                acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end
        end else begin
            if (acc[0]) begin
                acc_next = {sum, acc[XLEN-1:1]};
            end else begin
                acc_next = {1'b0, acc[2*XLEN-1:1]};
            end
        end
    end

    // Sign fix-up applied to the final step's value
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rmd;

    always_comb begin
        prod = neg_q ? (~acc_next + 1'b1) : acc_next;
        quo  = neg_q ? (~acc_next[XLEN-1:0] + 1'b1) : acc_next[XLEN-1:0];
        rmd  = neg_rem_q ? (~acc_next[2*XLEN-1:XLEN] + 1'b1)
                         : acc_next[2*XLEN-1:XLEN];
        if (div_q) begin
            result = rem_q ? rmd : quo;
        end else begin
            result = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        end
    end

    assign done = busy && (count == CW'(XLEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            busy      <= 1'b0;
            acc       <= '0;
            mag_b     <= '0;
            div_q     <= 1'b0;
            hi_q      <= 1'b0;
            rem_q     <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (start) begin
            count     <= '0;
            busy      <= 1'b1;
            acc       <= {{XLEN{1'b0}}, mag_a_in};
            mag_b     <= mag_b_in;
            div_q     <= op inside {DIV, DIVU, REM, REMU};
            hi_q      <= op inside {MULH, MULHSU, MULHU};
            rem_q     <= op inside {REM, REMU};
            neg_q     <= neg_a ^ neg_b;
            neg_rem_q <= neg_a;
        end else if (busy) begin
            acc   <= acc_next;
            count <= count + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule
`endif

// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - multi-cycle RV32IM ALU with valid/ready handshakes
// Optional feature macro: ALU_MULDIV_EN (iterative mul/div; M ops give 0 otherwise)
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   in_valid, in_ready   operand handshake; transfer on in_valid & in_ready
//   op, a, b             operation and operands, captured at accept
//   out_valid, out_ready result handshake; result held until out_ready
//   result               registered XLEN-bit result
module alu_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  alu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    state_e          state;
    logic            accept;
    logic [XLEN-1:0] fast_res;
    logic [XLEN-1:0] diff;
    logic [SHW-1:0]  shamt;
    logic            slt;
    logic            md_iter;
    logic            md_done;
    logic [XLEN-1:0] md_result;

    // A finished result frees the block in the same cycle it is consumed.
    assign in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    assign diff  = a - b;
    assign shamt = b[SHW-1:0];
    // Differing signs decide directly; otherwise the difference cannot
    // overflow and its sign bit is the answer.
    assign slt   = (a[XLEN-1] != b[XLEN-1]) ? a[XLEN-1] : diff[XLEN-1];

`ifdef ALU_MULDIV_EN
    logic div_zero;
    logic div_ovf;

    assign div_zero = (op inside {DIV, DIVU, REM, REMU}) && (b == '0);
    assign div_ovf  = (op inside {DIV, REM}) &&
                      (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    assign md_iter  = is_muldiv(op) && !div_zero && !div_ovf;

    alu_muldiv_iter #(
        .XLEN(XLEN)
    ) u_muldiv (
        .clk    (clk),
        .rst    (reset),
        .start  (accept && md_iter),
        .op     (op),
        .a      (a),
        .b      (b),
        .done   (md_done),
        .result (md_result)
    );
`else
    assign md_iter   = 1'b0;
    assign md_done   = 1'b0;
    assign md_result = '0;
`endif

    // Single-cycle datapath, also covering the mul/div special cases
    always_comb begin
        fast_res = '0;
        case (op)
            ADD:  fast_res = a + b;
            SUB:  fast_res = diff;
            SLT:  fast_res = {{(XLEN-1){1'b0}}, slt};
            SLTU: fast_res = {{(XLEN-1){1'b0}}, (a < b)};
            XOR:  fast_res = a ^ b;
            OR:   fast_res = a | b;
            AND:  fast_res = a & b;
            SLL:  fast_res = a << shamt;
            SRL:  fast_res = a >> shamt;
            SRA:  fast_res = $unsigned($signed(a) >>> shamt);
`ifdef ALU_MULDIV_EN
            DIV, DIVU: fast_res = div_zero ? '1 : a;
            REM, REMU: fast_res = div_zero ? a : '0;
`endif
            default: fast_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        if (md_iter) begin
                            state     <= S_CALC;
                            out_valid <= 1'b0;
                        end else begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                            result    <= fast_res;
                        end
                    end else if ((state == S_DONE) && out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                S_CALC: begin
                    if (md_done) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        result    <= md_result;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
